// File: rtl/alu_result_log.sv
// Circular history of completed ALU operations with a newest-to-oldest browse
// cursor feeding the seven-segment display path.
module alu_result_log #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [2:0]                 wr_op,
  input  logic [5:0]                 wr_a,
  input  logic [5:0]                 wr_b,
  input  logic [6:0]                 wr_result,
  input  logic                       wr_cout,
  input  logic                       wr_ovf,
  input  logic                       step,
  input  logic                       clear,
  output logic [2:0]                 disp_op,
  output logic [5:0]                 disp_a,
  output logic [5:0]                 disp_b,
  output logic [6:0]                 disp_result,
  output logic                       disp_cout,
  output logic                       disp_ovf,
  output logic [$clog2(DEPTH)-1:0]   disp_age,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 24;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic [AW-1:0] age;
  logic          drop_q;
  logic [AW-1:0] sel;
  logic [EW-1:0] rd_entry;
  logic          at_full;
  logic          at_oldest;

  assign at_full   = (cnt == (AW+1)'(DEPTH));
  assign at_oldest = ({1'b0, age} == cnt - (AW+1)'(1));

  // Control state: pointer, occupancy, browse cursor, sticky overwrite flag
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      cnt    <= '0;
      age    <= '0;
      drop_q <= 1'b0;
    end else if (wr_valid) begin
      wr_ptr <= wr_ptr + AW'(1);
      age    <= '0;
      if (at_full) drop_q <= 1'b1;
      else         cnt    <= cnt + (AW+1)'(1);
    end else if (step && (cnt != '0)) begin
      if (at_oldest) age <= '0;
      else           age <= age + AW'(1);
    end
  end

  // Entry storage carries no reset; stale slots are masked by the empty check
  always_ff @(posedge clk) begin
    if (wr_valid && !rst && !clear)
      mem[wr_ptr] <= {wr_op, wr_a, wr_b, wr_result, wr_cout, wr_ovf};
  end

  assign sel      = wr_ptr - AW'(1) - age;
  assign rd_entry = empty ? '0 : mem[sel];

  assign {disp_op, disp_a, disp_b, disp_result, disp_cout, disp_ovf} = rd_entry;
  assign disp_age = age;
  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = at_full;
  assign dropped  = drop_q;

endmodule

// File: tb/tb_alu_result_log.sv
// Randomized bench for alu_result_log against a queue-based history model.
module tb_alu_result_log;

  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);

  logic          clk, rst, wr_valid, step, clear;
  logic [2:0]    wr_op;
  logic [5:0]    wr_a, wr_b;
  logic [6:0]    wr_result;
  logic          wr_cout, wr_ovf;
  logic [2:0]    disp_op;
  logic [5:0]    disp_a, disp_b;
  logic [6:0]    disp_result;
  logic          disp_cout, disp_ovf;
  logic [AW-1:0] disp_age;
  logic [AW:0]   count;
  logic          empty, full, dropped;

  alu_result_log #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_op(wr_op), .wr_a(wr_a),
    .wr_b(wr_b), .wr_result(wr_result), .wr_cout(wr_cout), .wr_ovf(wr_ovf),
    .step(step), .clear(clear), .disp_op(disp_op), .disp_a(disp_a),
    .disp_b(disp_b), .disp_result(disp_result), .disp_cout(disp_cout),
    .disp_ovf(disp_ovf), .disp_age(disp_age), .count(count), .empty(empty),
    .full(full), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: history as a queue, oldest at the front, newest at the back
  logic [23:0] hist[$];
  int          m_age;
  bit          m_drop;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(input logic [6:0] res);
    return {3'($urandom), 6'($urandom), 6'($urandom), res, 1'($urandom), 1'($urandom)};
  endfunction

  function automatic logic [23:0] exp_entry();
    if (hist.size() == 0) return '0;
    return hist[hist.size() - 1 - m_age];
  endfunction

  task automatic cycle(input bit r, input bit c, input bit w, input bit s,
                       input logic [23:0] e);
    rst = r; clear = c; wr_valid = w; step = s;
    {wr_op, wr_a, wr_b, wr_result, wr_cout, wr_ovf} = e;
    @(posedge clk);
    if (r || c) begin
      hist.delete(); m_age = 0; m_drop = 0;
    end else if (w) begin
      if (hist.size() == DEPTH) begin
        void'(hist.pop_front()); m_drop = 1;
      end
      hist.push_back(e); m_age = 0;
    end else if (s && hist.size() > 0) begin
      m_age = (m_age == hist.size() - 1) ? 0 : m_age + 1;
    end
    #1;
    rst = 0; clear = 0; wr_valid = 0; step = 0;
    chk("entry", {disp_op, disp_a, disp_b, disp_result, disp_cout, disp_ovf}, exp_entry());
    chk("age",   24'(disp_age), 24'(m_age));
    chk("count", 24'(count),    24'(hist.size()));
    chk("flags", {21'd0, empty, full, dropped},
        {21'd0, hist.size() == 0, hist.size() == DEPTH, m_drop});
  endtask

  initial begin
    rst = 0; clear = 0; wr_valid = 0; step = 0;
    {wr_op, wr_a, wr_b, wr_result, wr_cout, wr_ovf} = '0;
    m_age = 0; m_drop = 0;

    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    chk("rst_empty", 24'(empty), 24'd1);

    // Single write: op=000 a=5 b=3 result=8
    cycle(0, 0, 1, 0, {3'd0, 6'd5, 6'd3, 7'd8, 1'b0, 1'b0});
    chk("single_res", 24'(disp_result), 24'd8);
    cycle(0, 0, 0, 1, '0);
    cycle(0, 0, 0, 1, '0);
    chk("single_age", 24'(disp_age), 24'd0);

    // Browse after three writes
    cycle(1, 0, 0, 0, '0);
    for (int i = 1; i <= 3; i++) cycle(0, 0, 1, 0, mk(7'(i)));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, '0);
    chk("browse_wrap", 24'(disp_result), 24'd3);

    // Overflow: results 1..9, then walk back to the oldest survivor
    cycle(0, 1, 0, 0, '0);
    for (int i = 1; i <= 9; i++) cycle(0, 0, 1, 0, mk(7'(i)));
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, '0);
    chk("ovf_oldest", 24'(disp_result), 24'd2);

    // Step with write, clear with write, steps while empty
    cycle(0, 0, 1, 1, mk(7'd42));
    chk("wr_step", 24'(disp_result), 24'd42);
    cycle(0, 1, 1, 0, mk(7'd99));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, '0);
    chk("empty_res", 24'(disp_result), 24'd0);

    // Random mix, writes biased so the log fills and wraps often
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(199) == 0, $urandom_range(79) == 0,
            $urandom_range(2) == 0, $urandom_range(1) == 1,
            mk(7'($urandom)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_log.md
# alu_result_log

Eight-entry circular history of completed ALU operations, sitting directly downstream of the ALU result register stage. It captures each executed instruction's opcode, operands, result and carry/overflow flags on a one-cycle strobe from the result stage. Captured entries can be browsed newest-to-oldest with an edge-detected push-button step. The selected entry drives the seven-segment decoders, so the operator can review earlier results after the FIFO has drained.

## Interface
- DEPTH, 8: number of history entries; must be a power of 2, at least 2.
- clk  in  1  system clock; the same divided clock as the FIFO and ALU stages.
- rst  in  1  synchronous, active-high reset (the synchronised reset).
- wr_valid  in  1  one-cycle strobe; high when the result stage has just registered a new result.
- wr_op  in  3  opcode of the executed instruction (instruction bits 14:12).
- wr_a  in  6  operand A.
- wr_b  in  6  operand B.
- wr_result  in  7  result value as registered by the result stage.
- wr_cout  in  1  carry-out of the executed operation (0 for compare ops).
- wr_ovf  in  1  overflow of the executed operation (0 for compare ops).
- step  in  1  one-cycle pulse from the edge detector; advances the browse cursor.
- clear  in  1  level; empties the log while high.
- disp_op  out  3  opcode of the selected entry.
- disp_a  out  6  operand A of the selected entry.
- disp_b  out  6  operand B of the selected entry.
- disp_result  out  7  result of the selected entry.
- disp_cout  out  1  carry-out of the selected entry.
- disp_ovf  out  1  overflow of the selected entry.
- disp_age  out  log2(DEPTH)  age of the selected entry; 0 is the newest.
- count  out  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  out  1  high when count==0.
- full  out  1  high when count==DEPTH.
- dropped  out  1  sticky; set when an entry is overwritten.

## Operation
- Storage: DEPTH x 24-bit entries {op, a, b, result, cout, ovf} held in flops; wr_ptr points to the next slot to write.
- Priority within one cycle: rst > clear > wr_valid > step.
- rst or clear: wr_ptr=0, count=0, age=0, dropped=0. Entry contents need not be zeroed.
- wr_valid (no clear):
  - Store the entry at wr_ptr; wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH.
  - If count==DEPTH before the write, the oldest entry is overwritten and dropped is set.
  - age is forced to 0 so the display snaps to the newest entry.
  - A step in the same cycle is ignored.
- step (no clear, no wr_valid):
  - If count==0: ignored.
  - Else if age==count-1: age wraps to 0.
  - Else: age increments.
- Selected slot = (wr_ptr - 1 - age) mod DEPTH.
- When empty=1, all disp_* outputs read 0, regardless of stale storage.
- disp_age equals the internal age.

## Timing
- All state updates on the rising edge of clk. disp_* outputs are combinational from registered state: no combinational path from any input.
- Latency: a write or step sampled at edge N is visible on disp_*, count, full, empty and dropped immediately after edge N.
- Back-to-back wr_valid on consecutive cycles: every strobe is captured; no strobe is lost.
- Reset values: every output is 0 except empty=1.
- Reset or clear asserted mid-browse: the log is empty after that edge, and the next write lands in slot 0.
- Wrap-around: wr_ptr DEPTH-1 -> 0. With count==DEPTH, age range is 0..DEPTH-1 and the oldest visible entry is the slot at wr_ptr.

## Test plan
- Reset: assert rst 2 cycles -> all disp_*=0, count=0, empty=1, full=0, dropped=0.
- Single write: wr_valid with op=000, a=5, b=3, result=8, cout=0, ovf=0 -> next cycle disp_result=8, disp_a=5, disp_b=3, count=1, disp_age=0. Two steps -> disp_age stays 0 (wraps) and values unchanged.
- Browse: write results 1,2,3 on consecutive cycles -> disp_result=3. Steps -> 2, 1, then 3 with disp_age 1, 2, 0.
- Overflow: write results 1..9 (DEPTH=8) -> count=8, full=1, dropped=1. Stepping 7 times shows 8,7,...,2; result 1 never appears.
- Simultaneous events: step together with wr_valid (result=42) -> disp_result=42, disp_age=0. Clear together with wr_valid -> count=0, empty=1, disp_result=0.
- Step while empty: after clear, pulse step 3 times -> disp_age=0, all disp_*=0, count=0.
